// File: rtl/timer_irq.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers.
// It raises a maskable interrupt request when the countdown expires.
module timer_irq #(
  parameter logic [31:0] MIN_PRESET = 32'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      r_state;
  logic        r_enable;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pending;
  logic        r_pulse;

  logic        w_ctrl_wr;
  logic        w_preset_wr;
  logic        w_auto;
  logic [31:0] w_preset_val;

  assign w_ctrl_wr    = WE && (Addr == 2'd0);
  assign w_preset_wr  = WE && (Addr == 2'd1);
  assign w_auto       = (r_mode == 2'b01);
  assign w_preset_val = (Din > MIN_PRESET) ? Din : MIN_PRESET;

  assign IRQ = r_im & r_pending;

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      2'd0:    Dout = {28'd0, r_im, r_mode, r_enable};
      2'd1:    Dout = r_preset;
      2'd2:    Dout = r_count;
      default: Dout = 32'd0;
    endcase
  end

  // The CTRL write sits last so a CPU write beats the FSM's enable-clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_enable  <= 1'b0;
      r_mode    <= 2'b00;
      r_im      <= 1'b0;
      r_preset  <= 32'd0;
      r_count   <= 32'd0;
      r_pending <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (r_pulse) r_pending <= 1'b0;
      if (w_preset_wr) r_preset <= w_preset_val;

      case (r_state)
        S_IDLE: begin
          if (r_enable) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_enable) begin
            r_state <= S_IDLE;
          end else if (r_count <= 32'd1) begin
            r_count <= 32'd0;
            r_state <= S_INT;
          end else begin
            r_count <= r_count - 32'd1;
          end
        end
        S_INT: begin
          r_pending <= 1'b1;
          if (w_auto) begin
            r_pulse <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_enable <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_ctrl_wr) begin
        r_enable  <= Din[0];
        r_mode    <= Din[2:1];
        r_im      <= Din[3];
        r_pending <= 1'b0;
        r_pulse   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Directed-plus-random bench for timer_irq; expected IRQ/COUNT come from
// closed-form timing rules (latency N+3, reload period N+2).
module tb_timer_irq;

  logic        Clk;
  logic        Reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int nCmp;
  int nFail;

  timer_irq dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  function automatic int nEff(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic logic [31:0] oneShotCount(input int n, input int m, input logic [31:0] prev);
    if (m < 2) return prev;
    return (n - (m - 2) > 0) ? 32'(n - (m - 2)) : 32'd0;
  endfunction

  function automatic logic oneShotIrq(input int n, input int m);
    return (m >= nEff(n) + 3);
  endfunction

  function automatic logic [31:0] autoCount(input int n, input int m, input logic [31:0] prev);
    int r;
    if (m < 2) return prev;
    r = (m - 2) % (nEff(n) + 2);
    return (n - r > 0) ? 32'(n - r) : 32'd0;
  endfunction

  function automatic logic autoIrq(input int n, input int m);
    int first;
    first = nEff(n) + 3;
    return (m >= first) && (((m - first) % (nEff(n) + 2)) == 0);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = Dout;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic checkCycle(input string tag, input logic expIrq, input logic [31:0] expCnt);
    logic [31:0] v;
    checkOutput({tag, " irq"}, {31'd0, IRQ}, {31'd0, expIrq});
    readReg(2'd2, v);
    checkOutput({tag, " count"}, v, expCnt);
  endtask

  task automatic pulseReset(input string tag);
    logic [31:0] v;
    Reset = 1'b0;
    #1;
    checkOutput({tag, " irq"}, {31'd0, IRQ}, 32'd0);
    readReg(2'd0, v);
    checkOutput({tag, " ctrl"}, v, 32'd0);
    readReg(2'd1, v);
    checkOutput({tag, " preset"}, v, 32'd0);
    readReg(2'd2, v);
    checkOutput({tag, " count"}, v, 32'd0);
    Reset = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] frozen;
    int          n;
    int          mw;
    int          newp;
    int          oneShotN[3];
    int          autoN[2];

    nCmp  = 0;
    nFail = 0;
    Reset = 1'b0;
    Addr  = 2'd0;
    WE    = 1'b0;
    Din   = 32'd0;

    // Reset state
    #3;
    checkOutput("reset irq", {31'd0, IRQ}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), v);
      checkOutput($sformatf("reset read addr%0d", a), v, 32'd0);
    end
    tick();
    tick();
    Reset = 1'b1;
    tick();

    // One-shot with IM: level IRQ held, cleared by CTRL write
    oneShotN[0] = 5;
    oneShotN[1] = 0;
    oneShotN[2] = int'($urandom_range(1, 7));
    for (int t = 0; t < 3; t++) begin
      n = oneShotN[t];
      applyStimulus(2'd1, 32'(n));
      readReg(2'd1, v);
      checkOutput("preset readback", v, 32'(n));
      applyStimulus(2'd0, 32'h9);
      for (int m = 1; m <= nEff(n) + 23; m++) begin
        tick();
        checkCycle($sformatf("oneshot n=%0d m=%0d", n, m), oneShotIrq(n, m), oneShotCount(n, m, 32'd0));
      end
      readReg(2'd0, v);
      checkOutput("oneshot enable cleared", v, 32'h8);
      applyStimulus(2'd0, 32'h0);
      checkOutput("oneshot ack irq", {31'd0, IRQ}, 32'd0);
    end

    // Masked expiry, then unmasking must not raise IRQ
    n = int'($urandom_range(0, 4));
    applyStimulus(2'd1, 32'(n));
    applyStimulus(2'd0, 32'h1);
    for (int m = 1; m <= nEff(n) + 6; m++) begin
      tick();
      checkCycle($sformatf("masked n=%0d m=%0d", n, m), 1'b0, oneShotCount(n, m, 32'd0));
    end
    readReg(2'd0, v);
    checkOutput("masked expiry cleared enable", v, 32'h0);
    applyStimulus(2'd0, 32'h8);
    for (int m = 1; m <= 5; m++) begin
      tick();
      checkOutput($sformatf("unmask no irq m=%0d", m), {31'd0, IRQ}, 32'd0);
    end
    applyStimulus(2'd0, 32'h0);

    // CTRL write on the expiry edge keeps Enable and acknowledges
    n = int'($urandom_range(1, 5));
    applyStimulus(2'd1, 32'(n));
    applyStimulus(2'd0, 32'h9);
    for (int m = 1; m < nEff(n) + 3; m++) begin
      tick();
      checkCycle($sformatf("race n=%0d m=%0d", n, m), 1'b0, oneShotCount(n, m, 32'd0));
    end
    applyStimulus(2'd0, 32'h9);
    readReg(2'd0, v);
    checkOutput("race ctrl wins", v, 32'h9);
    checkOutput("race irq acked", {31'd0, IRQ}, 32'd0);
    for (int m = 1; m <= nEff(n) + 4; m++) begin
      tick();
      checkCycle($sformatf("race rerun m=%0d", m), oneShotIrq(n, m), oneShotCount(n, m, 32'd0));
    end
    applyStimulus(2'd0, 32'h0);

    // Disable mid-count freezes COUNT; re-enable reloads; PRESET write mid-count
    n    = int'($urandom_range(6, 12));
    mw   = int'($urandom_range(3, n));
    newp = int'($urandom_range(20, 40));
    applyStimulus(2'd1, 32'(n));
    applyStimulus(2'd0, 32'h9);
    for (int m = 1; m < mw; m++) begin
      tick();
      checkCycle($sformatf("middis n=%0d m=%0d", n, m), 1'b0, oneShotCount(n, m, 32'd0));
    end
    applyStimulus(2'd0, 32'h0);
    frozen = oneShotCount(n, mw, 32'd0);
    for (int m = 0; m <= 8; m++) begin
      checkCycle($sformatf("frozen k=%0d", m), 1'b0, frozen);
      tick();
    end
    applyStimulus(2'd0, 32'h9);
    for (int m = 1; m <= n + 6; m++) begin
      if (m == 4) applyStimulus(2'd1, 32'(newp));
      else tick();
      checkCycle($sformatf("reload n=%0d m=%0d", n, m), oneShotIrq(n, m), oneShotCount(n, m, frozen));
    end
    readReg(2'd1, v);
    checkOutput("preset written mid-count", v, 32'(newp));
    applyStimulus(2'd0, 32'h0);

    // Auto-reload pulses, each trial ended by an asynchronous reset
    autoN[0] = 3;
    autoN[1] = int'($urandom_range(0, 6));
    for (int t = 0; t < 2; t++) begin
      n = autoN[t];
      applyStimulus(2'd1, 32'(n));
      applyStimulus(2'd0, 32'hB);
      for (int m = 1; m <= nEff(n) + 3 + 3 * (nEff(n) + 2); m++) begin
        tick();
        checkCycle($sformatf("auto n=%0d m=%0d", n, m), autoIrq(n, m), autoCount(n, m, 32'd0));
      end
      pulseReset("auto reset");
      tick();
    end

    // Reset asserted mid-count with auto-reload
    applyStimulus(2'd1, 32'd9);
    applyStimulus(2'd0, 32'hB);
    for (int m = 1; m <= 4; m++) begin
      tick();
      checkCycle($sformatf("pre-reset m=%0d", m), autoIrq(9, m), autoCount(9, m, 32'd0));
    end
    pulseReset("midcount reset");
    for (int m = 1; m <= 15; m++) begin
      tick();
      checkCycle($sformatf("post-reset m=%0d", m), 1'b0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
